// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory responder with optional wait states.
// Optional feature macro: MEM_WAIT_EN (compiles in WAIT state and wait counter).
`default_nettype none

module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] W_data,
  output logic [31:0] R_data,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);

`ifdef MEM_WAIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  logic [3:0] cnt;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

  state_t state, state_next;

  logic [31:0] addr_q, wdata_q;
  logic        rd_q, wr_q, err_q;
  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  logic              req;
  logic              enter_resp;
  logic [31:0]       acc_addr, acc_wdata;
  logic              acc_rd, acc_wr, acc_err;
  logic [ADDR_W-1:0] acc_idx;

  assign req = MemRd | MemWr;

  // Without wait states RESP is entered on the accepting edge, so the access
  // must use the live inputs rather than the copies being latched on that edge.
  assign acc_addr  = (state == S_IDLE) ? Addr   : addr_q;
  assign acc_wdata = (state == S_IDLE) ? W_data : wdata_q;
  assign acc_rd    = (state == S_IDLE) ? MemRd  : rd_q;
  assign acc_wr    = (state == S_IDLE) ? MemWr  : wr_q;
  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00)
                   | ((acc_addr >> (ADDR_W + 2)) != 32'h0)
                   | (acc_rd & acc_wr);

  assign enter_resp = (state_next == S_RESP);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req) begin
`ifdef MEM_WAIT_EN
          state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
`else
          state_next = S_RESP;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
      end
`endif
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state   <= S_IDLE;
      R_data  <= 32'h0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
`ifdef MEM_WAIT_EN
      cnt     <= 4'd0;
`endif
    end else begin
      state <= state_next;
      if (state == S_IDLE && req) begin
        addr_q  <= Addr;
        wdata_q <= W_data;
        rd_q    <= MemRd;
        wr_q    <= MemWr;
      end
`ifdef MEM_WAIT_EN
      if (state == S_IDLE && req)
        cnt <= WAIT_LOAD;
      else if (state == S_WAIT)
        cnt <= cnt - 4'd1;
`endif
      if (enter_resp) begin
        err_q <= acc_err;
        if (acc_err)
          R_data <= 32'h0;
        else if (acc_rd)
          R_data <= mem[acc_idx];
      end
    end
  end

  // Array is never cleared; reset only blocks the write on the RESP entry edge.
  always_ff @(posedge CLK) begin
    if (reset && enter_resp && acc_wr && !acc_err)
      mem[acc_idx] <= acc_wdata;
  end

  assign Ready = (state == S_RESP);
  assign Err   = (state == S_RESP) & err_q;
  assign Busy  = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven scoreboard bench for mem_responder.
`default_nettype none

module tb_mem_responder;

`ifdef MEM_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif
  localparam int LAT = 1 + W;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] W_data = 32'h0;
  logic [31:0] R_data;
  logic        Ready, Err, Busy;

  int checks = 0;
  int failures = 0;

  mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .CLK(CLK), .reset(reset), .MemRd(MemRd), .MemWr(MemWr),
    .Addr(Addr), .W_data(W_data), .R_data(R_data),
    .Ready(Ready), .Err(Err), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one request, hold it until Ready, then compare against the queued expectation.
  task automatic access(input vec_t v, input string name);
    int   cycles;
    logic got;
    logic busy_ok;
    vec_t e;
    exp_q.push_back(v);
    @(negedge CLK);
    MemRd = v.rd; MemWr = v.wr; Addr = v.addr; W_data = v.wdata;
    cycles = 0; got = 1'b0; busy_ok = 1'b1;
    while (cycles < 40 && !got) begin
      @(posedge CLK); #1;
      cycles++;
      if (!Busy) busy_ok = 1'b0;
      if (Ready) got = 1'b1;
    end
    MemRd = 1'b0; MemWr = 1'b0;
    e = exp_q.pop_front();
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_ready required=ready_within_40", name);
    end else begin
      chk({name, "_rdata"}, R_data, e.exp_rdata);
      chk({name, "_err"}, 32'(Err), 32'(e.exp_err));
      chk({name, "_latency"}, 32'(cycles), 32'(LAT));
      chk({name, "_busy"}, 32'(busy_ok), 32'd1);
    end
    @(posedge CLK); #1;
    chk({name, "_idle_after"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hA5A5_0001, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0020, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h5555_5555, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'hA5A5_0001, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_0020, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0BAD_F00D, 1'b0};

    // Reset held with a pending read: everything stays quiet.
    reset = 1'b0; MemRd = 1'b1; Addr = 32'h0000_0010;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("reset_ready", 32'(Ready), 32'd0);
      chk("reset_err",   32'(Err),   32'd0);
      chk("reset_busy",  32'(Busy),  32'd0);
      chk("reset_rdata", R_data,     32'h0);
    end
    @(negedge CLK);
    MemRd = 1'b0; reset = 1'b1;

    for (int i = 0; i < 13; i++)
      access(vecs[i], $sformatf("vec%0d", i));

`ifdef MEM_WAIT_EN
    // Reset in the second WAIT cycle of a write must abort it.
    begin
      vec_t rb;
      @(negedge CLK);
      MemWr = 1'b1; Addr = 32'h0000_0040; W_data = 32'h1234_5678;
      @(posedge CLK); #1;
      chk("abort_wait1_busy",  32'(Busy),  32'd1);
      chk("abort_wait1_ready", 32'(Ready), 32'd0);
      @(posedge CLK); #1;
      chk("abort_wait2_ready", 32'(Ready), 32'd0);
      reset = 1'b0; MemWr = 1'b0;
      @(posedge CLK); #1;
      chk("abort_ready", 32'(Ready), 32'd0);
      chk("abort_busy",  32'(Busy),  32'd0);
      @(negedge CLK);
      reset = 1'b1;
      @(posedge CLK); #1;
      chk("abort_idle", 32'(Busy), 32'd0);
      rb = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0040, 1'b0};
      access(rb, "abort_readback");
    end
`else
    // Strobe held high: a new access every second cycle.
    begin
      logic exp_b [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      @(negedge CLK);
      MemRd = 1'b1; Addr = 32'h0000_0010;
      for (int i = 0; i < 8; i++) begin
        @(posedge CLK); #1;
        chk($sformatf("b2b_busy%0d", i),  32'(Busy),  32'(exp_b[i]));
        chk($sformatf("b2b_ready%0d", i), 32'(Ready), 32'(exp_b[i]));
        if (exp_b[i]) chk($sformatf("b2b_rdata%0d", i), R_data, 32'hDEAD_BEEF);
        if (i == 6) MemRd = 1'b0;
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
